response_checker: RTL and testbench
===================================

# response_checker

Self-checking response monitor for the generated benchmark flow: the receiving end of the stimulus/expected-value stream that directed testbenches drive into each unit under test. It accepts one (observed, expected) vector pair per handshake, compares them bitwise with XOR, and keeps test and failure counts plus the index of the first failing test. It sits beside the UUT in synthesizable self-test wrappers, so benchmarks can run on hardware without `$display` inspection.

## Interface
- `WIDTH`, 1: width of the compared UUT output vector.
- `CNT_W`, 16: width of the test counter, failure counter and failure index.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that clears the counters and begins a run.
- `vec_valid`  in  1  an observed/expected pair is presented.
- `vec_ready`  out  1  checker can accept a pair.
- `vec_last`  in  1  the presented pair is the final test of the run.
- `observed`  in  WIDTH  UUT output sampled by the driver.
- `expected`  in  WIDTH  golden value for this test.
- `busy`  out  1  run in progress.
- `done`  out  1  run complete; held until the next `start`.
- `pass`  out  1  `done` asserted and `fail_count == 0`.
- `test_count`  out  CNT_W  number of pairs accepted this run.
- `fail_count`  out  CNT_W  number of mismatching pairs this run.
- `first_fail_valid`  out  1  at least one mismatch has been captured.
- `first_fail_idx`  out  CNT_W  test index (0-based) of the first mismatch.

## Operation
- Reset: the FSM goes to IDLE. Every output is 0, including `vec_ready`.
- FSM states: IDLE, RUN, DONE.
  - IDLE, on `start`: go to RUN and clear all counters and failure capture.
  - RUN: `vec_ready = 1` and `busy = 1`. When an accept occurs with `vec_last = 1`, go to DONE.
  - DONE: `done = 1`, `vec_ready = 0`. On `start`, clear and go to RUN.
- `start` while in RUN is ignored; the run cannot be aborted except by `rst_n`.
- Accept is `vec_valid && vec_ready`. A mismatch is `|(observed ^ expected)`.
- On an accept:
  - `test_count` increments.
  - On a mismatch, `fail_count` increments.
  - If `first_fail_valid == 0`, the current `test_count` (the pre-increment index) is latched into `first_fail_idx` and `first_fail_valid` is set.
- Both counters saturate at 2^CNT_W−1. Once saturated they stop counting and do not wrap. `first_fail_idx` saturates the same way.
- Inputs are ignored when not accepted.
- Reset mid-run: all state clears asynchronously. The checker returns to IDLE and requires a new `start`.

## Timing
- Counter and flag updates are registered, so they are visible one cycle after the accepting edge.
- `vec_ready` rises in the cycle after the `start` edge.
- Throughput is one pair per cycle while in RUN.
- `done` and `pass` assert the cycle after the edge that accepted `vec_last`. In that same cycle `vec_ready` falls.
- A `start` in DONE clears `done`, `pass` and the counters on the next edge.

## Configuration
- `RESPONSE_CHECKER_MASK_EN` defined:
  - Adds input `mask` [WIDTH-1:0]. Set bits are don't-care.
  - A mismatch becomes `|((observed ^ expected) & ~mask)`.
- `RESPONSE_CHECKER_MASK_EN` undefined:
  - No `mask` port.
  - Every bit is compared.

## Test plan
- XOR truth-table run, WIDTH=1: pairs (0,0),(1,1),(1,1),(0,0) with `last` on the 4th → `test_count=4`, `fail_count=0`, `pass=1`, `first_fail_valid=0`.
- Injected failures: pairs 0–3 with observed≠expected at index 1 and 3 → `fail_count=2`, `first_fail_idx=1`, `pass=0`, `done=1`.
- Backpressure and gaps: `vec_valid` toggled 1/0 over 6 cycles, and `start` pulsed mid-RUN → only valid cycles counted, the mid-RUN `start` ignored, `done` only after `last`.
- Saturation with CNT_W=3: 10 mismatching pairs → `test_count=7`, `fail_count=7`, `first_fail_idx=0`.
- Reset mid-run: `rst_n` low after 2 accepts → all outputs 0 immediately; after `start`, counting restarts from 0.
- Mask (macro defined, WIDTH=4): observed=4'b1010, expected=4'b1000, mask=4'b0010 → no failure. The same pair with mask=0 → `fail_count=1`.

Source files
------------

// File: rtl/response_checker.sv
// Response monitor: accepts observed/expected pairs, counts tests and mismatches,
// and captures the first failing index. Optional RESPONSE_CHECKER_MASK_EN adds a don't-care mask.
module response_checker #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             vec_valid,
    output logic             vec_ready,
    input  logic             vec_last,
    input  logic [WIDTH-1:0] observed,
    input  logic [WIDTH-1:0] expected,
`ifdef RESPONSE_CHECKER_MASK_EN
    input  logic [WIDTH-1:0] mask,
`endif
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] test_count,
    output logic [CNT_W-1:0] fail_count,
    output logic             first_fail_valid,
    output logic [CNT_W-1:0] first_fail_idx
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [CNT_W-1:0] CntMax = '1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] test_cnt_q, test_cnt_d;
    logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
    logic             ffv_q, ffv_d;
    logic [CNT_W-1:0] ffi_q, ffi_d;
    logic             clear;
    logic             accept;
    logic             mismatch;
    logic [WIDTH-1:0] diff;

`ifdef RESPONSE_CHECKER_MASK_EN
    assign diff = (observed ^ expected) & ~mask;
`else
    assign diff = observed ^ expected;
`endif

    assign mismatch = |diff;
    assign accept   = vec_valid && vec_ready;

    always_comb begin
        state_d = state_q;
        clear   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    clear   = 1'b1;
                end
            end
            StRun: begin
                // start is deliberately ignored here; only rst_n aborts a run
                if (accept && vec_last) state_d = StDone;
            end
            StDone: begin
                if (start) begin
                    state_d = StRun;
                    clear   = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        test_cnt_d = test_cnt_q;
        fail_cnt_d = fail_cnt_q;
        ffv_d      = ffv_q;
        ffi_d      = ffi_q;
        if (clear) begin
            test_cnt_d = '0;
            fail_cnt_d = '0;
            ffv_d      = 1'b0;
            ffi_d      = '0;
        end else if (accept) begin
            if (test_cnt_q != CntMax) test_cnt_d = test_cnt_q + CNT_W'(1);
            if (mismatch) begin
                if (fail_cnt_q != CntMax) fail_cnt_d = fail_cnt_q + CNT_W'(1);
                // Pre-increment count is the 0-based index; it is already saturated
                if (!ffv_q) begin
                    ffv_d = 1'b1;
                    ffi_d = test_cnt_q;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            test_cnt_q <= '0;
            fail_cnt_q <= '0;
            ffv_q      <= 1'b0;
            ffi_q      <= '0;
        end else begin
            state_q    <= state_d;
            test_cnt_q <= test_cnt_d;
            fail_cnt_q <= fail_cnt_d;
            ffv_q      <= ffv_d;
            ffi_q      <= ffi_d;
        end
    end

    assign vec_ready        = (state_q == StRun);
    assign busy             = (state_q == StRun);
    assign done             = (state_q == StDone);
    assign pass             = (state_q == StDone) && (fail_cnt_q == '0);
    assign test_count       = test_cnt_q;
    assign fail_count       = fail_cnt_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_idx   = ffi_q;

endmodule

// File: tb/tb_response_checker.sv
// Bench for response_checker: behavioural model checked every cycle plus literal pins.
// Build with RESPONSE_CHECKER_MASK_EN to exercise the mask port.
module tb_response_checker;

    localparam int W     = 4;
    localparam int CW    = 3;
    localparam int SATV  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          vec_valid;
    logic          vec_ready;
    logic          vec_last;
    logic [W-1:0]  observed;
    logic [W-1:0]  expected;
    logic [W-1:0]  mask;
    logic          busy;
    logic          done;
    logic          pass;
    logic [CW-1:0] test_count;
    logic [CW-1:0] fail_count;
    logic          first_fail_valid;
    logic [CW-1:0] first_fail_idx;

    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 1'b0;

    // Model: mode 0 idle, 1 running, 2 finished
    int m_mode  = 0;
    int m_tests = 0;
    int m_fails = 0;
    int m_ffv   = 0;
    int m_ffi   = 0;

    always #5 clk = ~clk;

    response_checker #(
        .WIDTH (W),
        .CNT_W (CW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .vec_valid        (vec_valid),
        .vec_ready        (vec_ready),
        .vec_last         (vec_last),
        .observed         (observed),
        .expected         (expected),
`ifdef RESPONSE_CHECKER_MASK_EN
        .mask             (mask),
`endif
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .test_count       (test_count),
        .fail_count       (fail_count),
        .first_fail_valid (first_fail_valid),
        .first_fail_idx   (first_fail_idx)
    );

    function automatic bit model_mismatch(logic [W-1:0] o, logic [W-1:0] e, logic [W-1:0] m);
`ifdef RESPONSE_CHECKER_MASK_EN
        return ((o ^ e) & ~m) != '0;
`else
        return (o ^ e) != '0;
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode  <= 0;
            m_tests <= 0;
            m_fails <= 0;
            m_ffv   <= 0;
            m_ffi   <= 0;
        end else if (m_mode != 1) begin
            if (start) begin
                m_mode  <= 1;
                m_tests <= 0;
                m_fails <= 0;
                m_ffv   <= 0;
                m_ffi   <= 0;
            end
        end else if (vec_valid) begin
            m_tests <= (m_tests < SATV) ? m_tests + 1 : SATV;
            if (model_mismatch(observed, expected, mask)) begin
                m_fails <= (m_fails < SATV) ? m_fails + 1 : SATV;
                if (m_ffv == 0) begin
                    m_ffv <= 1;
                    m_ffi <= m_tests;
                end
            end
            if (vec_last) m_mode <= 2;
        end
    end

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            chk("vec_ready", int'(vec_ready), int'(m_mode == 1));
            chk("busy", int'(busy), int'(m_mode == 1));
            chk("done", int'(done), int'(m_mode == 2));
            chk("pass", int'(pass), int'(m_mode == 2 && m_fails == 0));
            chk("test_count", int'(test_count), m_tests);
            chk("fail_count", int'(fail_count), m_fails);
            chk("first_fail_valid", int'(first_fail_valid), m_ffv);
            chk("first_fail_idx", int'(first_fail_idx), m_ffi);
        end
    end

    task automatic vec(input bit v, input logic [W-1:0] o, input logic [W-1:0] e,
                       input bit l, input bit s);
        vec_valid = v;
        observed  = o;
        expected  = e;
        vec_last  = l;
        start     = s;
        @(posedge clk);
        #2;
        vec_valid = 1'b0;
        vec_last  = 1'b0;
        start     = 1'b0;
    endtask

    task automatic do_start();
        vec(1'b0, '0, '0, 1'b0, 1'b1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ready"}, int'(vec_ready), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_pass"}, int'(pass), 0);
        chk({tag, "_tc"}, int'(test_count), 0);
        chk({tag, "_fc"}, int'(fail_count), 0);
        chk({tag, "_ffv"}, int'(first_fail_valid), 0);
        chk({tag, "_ffi"}, int'(first_fail_idx), 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        vec_valid = 1'b0;
        vec_last  = 1'b0;
        observed  = '0;
        expected  = '0;
        mask      = '0;
        repeat (2) @(posedge clk);
        #2;
        chk_zero("reset");
        rst_n    = 1'b1;
        checking = 1'b1;

        // Truth-table run: all pairs match
        do_start();
        chk("start_ready", int'(vec_ready), 1);
        vec(1'b1, 4'd0, 4'd0, 1'b0, 1'b0);
        vec(1'b1, 4'd1, 4'd1, 1'b0, 1'b0);
        vec(1'b1, 4'd1, 4'd1, 1'b0, 1'b0);
        vec(1'b1, 4'd0, 4'd0, 1'b1, 1'b0);
        chk("truth_tc", int'(test_count), 4);
        chk("truth_fc", int'(fail_count), 0);
        chk("truth_pass", int'(pass), 1);
        chk("truth_ffv", int'(first_fail_valid), 0);
        chk("truth_ready", int'(vec_ready), 0);
        chk("model_truth_tc", m_tests, 4);
        repeat (2) vec(1'b0, '0, '0, 1'b0, 1'b0);
        chk("done_held", int'(done), 1);

        // Injected failures at indices 1 and 3
        do_start();
        chk("restart_done", int'(done), 0);
        chk("restart_tc", int'(test_count), 0);
        vec(1'b1, 4'd5, 4'd5, 1'b0, 1'b0);
        vec(1'b1, 4'd3, 4'd2, 1'b0, 1'b0);
        vec(1'b1, 4'd8, 4'd8, 1'b0, 1'b0);
        vec(1'b1, 4'd0, 4'd15, 1'b1, 1'b0);
        chk("inj_tc", int'(test_count), 4);
        chk("inj_fc", int'(fail_count), 2);
        chk("inj_ffi", int'(first_fail_idx), 1);
        chk("inj_ffv", int'(first_fail_valid), 1);
        chk("inj_pass", int'(pass), 0);
        chk("inj_done", int'(done), 1);
        chk("model_inj_ffi", m_ffi, 1);

        // Gaps, ignored invalid last, ignored mid-run start
        do_start();
        vec(1'b1, 4'd1, 4'd1, 1'b0, 1'b0);
        vec(1'b0, 4'd1, 4'd0, 1'b0, 1'b1);
        vec(1'b1, 4'd2, 4'd3, 1'b0, 1'b0);
        vec(1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
        chk("gap_tc_mid", int'(test_count), 2);
        chk("gap_done_mid", int'(done), 0);
        vec(1'b1, 4'd0, 4'd0, 1'b1, 1'b0);
        vec(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
        chk("gap_tc", int'(test_count), 3);
        chk("gap_fc", int'(fail_count), 1);
        chk("gap_ffi", int'(first_fail_idx), 1);
        chk("gap_done", int'(done), 1);

        // Saturation: 10 mismatching pairs on a 3-bit counter
        do_start();
        for (int i = 0; i < 10; i++) begin
            vec(1'b1, 4'(i), 4'(i) ^ 4'd1, (i == 9), 1'b0);
        end
        chk("sat_tc", int'(test_count), 7);
        chk("sat_fc", int'(fail_count), 7);
        chk("sat_ffi", int'(first_fail_idx), 0);
        chk("sat_done", int'(done), 1);
        chk("model_sat_fc", m_fails, 7);

        // Asynchronous reset mid-run
        do_start();
        vec(1'b1, 4'd1, 4'd1, 1'b0, 1'b0);
        vec(1'b1, 4'd2, 4'd3, 1'b0, 1'b0);
        chk("pre_rst_tc", int'(test_count), 2);
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        vec(1'b1, 4'd2, 4'd3, 1'b1, 1'b0);
        chk("idle_ignore_tc", int'(test_count), 0);
        do_start();
        vec(1'b1, 4'd4, 4'd4, 1'b1, 1'b0);
        chk("post_rst_tc", int'(test_count), 1);
        chk("post_rst_pass", int'(pass), 1);

        // Masked compare
        do_start();
        mask = 4'b0010;
`ifdef RESPONSE_CHECKER_MASK_EN
        vec(1'b1, 4'b1010, 4'b1000, 1'b0, 1'b0);
        chk("mask_fc0", int'(fail_count), 0);
        mask = 4'b0000;
        vec(1'b1, 4'b1010, 4'b1000, 1'b1, 1'b0);
        chk("mask_fc1", int'(fail_count), 1);
        chk("mask_ffi", int'(first_fail_idx), 1);
`else
        vec(1'b1, 4'b1010, 4'b1000, 1'b1, 1'b0);
        chk("nomask_fc", int'(fail_count), 1);
        chk("nomask_ffi", int'(first_fail_idx), 0);
`endif
        vec(1'b0, '0, '0, 1'b0, 1'b0);

        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
